// File: rtl/operand_load_ctrl_pkg.sv
// Shared types and constants for the operand load controller.
//   ctrl_state_t    : FSM state encoding; it also drives state_dbg on the board display.
//   CTRL_MAX_CYCLES : default watchdog limit, in clk cycles, from exec_start to exec_done.
package operand_load_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD_X = 3'd1,
    ST_WAIT_Y = 3'd2,
    ST_LOAD_Y = 3'd3,
    ST_LAUNCH = 3'd4,
    ST_EXEC   = 3'd5,
    ST_DONE   = 3'd6,
    ST_ERROR  = 3'd7
  } ctrl_state_t;

  localparam int CTRL_MAX_CYCLES = 16;

endpackage

// File: rtl/operand_load_ctrl_edge_detect_rise.sv
// 1-bit rising-edge detector.
//   clk  : system clock
//   rst  : asynchronous, active-low reset (clears the history bit)
//   din  : level input, already synchronized/debounced
//   rise : high in the cycle where din is 1 and was 0 in the previous cycle
module edge_detect_rise (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic rise
);

  logic din_q;
  logic din_d;

  assign din_d = din;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) din_q <= 1'b0;
    else      din_q <= din_d;
  end

  // A held level produces exactly one rise.
  assign rise = din & ~din_q;

endmodule

// File: rtl/operand_load_ctrl.sv
// Operand load controller for the DE2-115 flow.
// Each start key press advances the sequence: capture X, capture Y, then
// launch the execution unit and wait for its done pulse, with a watchdog
// that stops a hung unit from stalling the board forever.
//   clk, rst      : clock, asynchronous active-low reset
//   start_key     : debounced start level (edge-detected here)
//   loaded_x/y    : loaded flags from the X/Y operand registers
//   exec_done     : single-cycle completion pulse from the execution unit
//   load_x/load_y : one-cycle load strobes to the operand registers
//   exec_start    : one-cycle launch pulse to the execution unit
//   busy          : high from LOAD_X through EXEC
//   result_valid  : result presentable on the display
//   timeout_err   : watchdog expired, held until the next accepted start
//   state_dbg     : encoded current state for 7-segment/LED debug
module operand_load_ctrl
  import operand_load_ctrl_pkg::*;
#(
  parameter int MAX_CYCLES = CTRL_MAX_CYCLES
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_key,
  input  logic       loaded_x,
  input  logic       loaded_y,
  input  logic       exec_done,
  output logic       load_x,
  output logic       load_y,
  output logic       exec_start,
  output logic       busy,
  output logic       result_valid,
  output logic       timeout_err,
  output logic [2:0] state_dbg
);

  localparam int CNT_W = $clog2(MAX_CYCLES + 1);
  localparam logic [CNT_W-1:0] WD_LAST = CNT_W'(MAX_CYCLES - 1);
  localparam logic [CNT_W-1:0] WD_SAT  = CNT_W'(MAX_CYCLES);

  ctrl_state_t      state_q, state_d;
  logic [CNT_W-1:0] wd_q, wd_d;
  logic             start_rise;

  edge_detect_rise u_start_edge (
    .clk  (clk),
    .rst  (rst),
    .din  (start_key),
    .rise (start_rise)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      wd_q    <= '0;
    end else begin
      state_q <= state_d;
      wd_q    <= wd_d;
    end
  end

  always_comb begin
    state_d = state_q;
    wd_d    = '0;
    unique case (state_q)
      // Idle and both terminal states accept a new run the same way.
      ST_IDLE, ST_DONE, ST_ERROR: if (start_rise) state_d = ST_LOAD_X;
      ST_LOAD_X:                  state_d = ST_WAIT_Y;
      ST_WAIT_Y:                  if (loaded_x && start_rise) state_d = ST_LOAD_Y;
      ST_LOAD_Y:                  state_d = ST_LAUNCH;
      ST_LAUNCH:                  if (loaded_y) state_d = ST_EXEC;
      ST_EXEC: begin
        // Completion wins over a watchdog expiry in the same cycle.
        if (exec_done)            state_d = ST_DONE;
        else if (wd_q == WD_LAST) state_d = ST_ERROR;
      end
      default:                    state_d = ST_IDLE;
    endcase

    // The counter already reads 1 in the first EXEC cycle (the launch cycle
    // counts as cycle 0), so expiry at MAX_CYCLES-1 lands ERROR exactly
    // MAX_CYCLES cycles after exec_start. Outside EXEC it is held at 0.
    if (state_d == ST_EXEC) begin
      wd_d = (wd_q == WD_SAT) ? wd_q : wd_q + 1'b1;
    end
  end

  // Moore decodes of the state register; exec_start additionally waits for
  // the Y register to confirm it has loaded.
  assign load_x       = (state_q == ST_LOAD_X);
  assign load_y       = (state_q == ST_LOAD_Y);
  assign exec_start   = (state_q == ST_LAUNCH) && loaded_y;
  assign busy         = (state_q == ST_LOAD_X) || (state_q == ST_WAIT_Y) ||
                        (state_q == ST_LOAD_Y) || (state_q == ST_LAUNCH) ||
                        (state_q == ST_EXEC);
  assign result_valid = (state_q == ST_DONE);
  assign timeout_err  = (state_q == ST_ERROR);
  assign state_dbg    = state_q;

endmodule

// File: doc/operand_load_ctrl.md
Name: operand_load_ctrl

Overview:
- Sequences the two operand registers (X, Y) and the iterative execution unit on the DE2-115 board flow.
- Each press of the board start key advances the flow: the first press captures X from the switches, the second captures Y, then the block launches the execution unit and waits for its done flag.
- Guards against a hung execution unit with a cycle watchdog and exposes its state for 7-segment/LED debug.

Parameters:
- MAX_CYCLES, 16: watchdog limit, in clk cycles, from exec_start to exec_done.
- CNT_W, $clog2(MAX_CYCLES+1): watchdog counter width (derived; not overridden).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- start_key  in  1  start request level, already synchronized/debounced; block edge-detects it
- loaded_x  in  1  loaded flag from the X operand register
- loaded_y  in  1  loaded flag from the Y operand register
- exec_done  in  1  execution unit completion, single-cycle pulse
- load_x  out  1  load strobe to X register
- load_y  out  1  load strobe to Y register
- exec_start  out  1  launch pulse to execution unit
- busy  out  1  high from LOAD_X through EXEC
- result_valid  out  1  result presentable on display
- timeout_err  out  1  watchdog expired, sticky until next accepted start
- state_dbg  out  3  encoded current state

Behaviour:
- Reset (async, rst=0): state=IDLE, all outputs 0, watchdog=0, edge-detect history=0.
- start_rise = start_key & ~start_key_q; start_key_q is registered every clk. Holding the key generates only one rise.
- All outputs are registered Moore decodes of state, except the counter logic.
- States: IDLE=0, LOAD_X=1, WAIT_Y=2, LOAD_Y=3, LAUNCH=4, EXEC=5, DONE=6, ERROR=7.
- IDLE: on start_rise -> LOAD_X; clear result_valid and timeout_err.
- LOAD_X: load_x=1 for exactly this one cycle -> WAIT_Y.
- WAIT_Y: start_rise is ignored until loaded_x=1. Once loaded_x=1 and start_rise -> LOAD_Y.
- LOAD_Y: load_y=1 for one cycle -> LAUNCH.
- LAUNCH: requires loaded_y=1. exec_start=1 for exactly one cycle, watchdog cleared -> EXEC. If loaded_y=0, hold in LAUNCH with exec_start=0.
- EXEC: watchdog increments by 1 each cycle.
  - exec_done=1 -> DONE. exec_done takes priority over a simultaneous watchdog expiry.
  - watchdog==MAX_CYCLES-1 without exec_done -> ERROR.
- DONE: result_valid=1, busy=0. On start_rise -> LOAD_X, same as from IDLE: result_valid clears, new X is captured.
- ERROR: timeout_err=1, busy=0. On start_rise -> LOAD_X, timeout_err clears.
- exec_done outside EXEC is ignored.
- start_rise in LOAD_X, LOAD_Y, LAUNCH or EXEC is dropped; it is not queued.
- Latency:
  - second key rise to exec_start = 2 cycles (LOAD_Y, LAUNCH);
  - exec_done to result_valid = 1 cycle.
- Watchdog saturates and never wraps. The counter is held at 0 outside EXEC.
- Reset mid-operation aborts immediately to IDLE. Operand registers share rst, so loaded_x and loaded_y also return to 0.
- busy=1 in LOAD_X, WAIT_Y, LOAD_Y, LAUNCH, EXEC.
- At most one of load_x, load_y, exec_start is high in any cycle.

Decomposition:
- Pkg_Global gets:
  - typedef enum logic [2:0] ctrl_state_t, with the encodings above;
  - constant CTRL_MAX_CYCLES = 16.
- One sub-module, edge_detect_rise (1-bit registered rising-edge detector, async active-low reset), instantiated for start_key.
- FSM and watchdog stay in operand_load_ctrl.

Test Plan:
- Nominal flow:
  - stimulus: reset; start_key rise; loaded_x returns 1 one cycle after load_x; second rise; loaded_y follows; exec_done 8 cycles after exec_start;
  - response: load_x, load_y and exec_start each pulse exactly once; exec_start occurs 2 cycles after the second rise; result_valid=1 one cycle after exec_done; state_dbg sequence 1,2,3,4,5,6.
- Key held high for 20 cycles in IDLE:
  - response: single load_x pulse; state stays WAIT_Y until the key is released and re-pressed.
- Watchdog:
  - stimulus: exec_done never asserted;
  - response: ERROR (state_dbg=7) and timeout_err=1 exactly 16 cycles after exec_start; the next start rise clears timeout_err and pulses load_x.
- Simultaneous events:
  - stimulus: exec_done coincides with watchdog==15;
  - response: DONE, result_valid=1, timeout_err=0.
- Early/stray inputs:
  - stimulus: exec_done pulse while in WAIT_Y; start rise while in EXEC;
  - response: both ignored; no state change, no extra strobes.
- Reset mid-EXEC:
  - stimulus: rst=0 asynchronously;
  - response: all outputs 0 and state_dbg=0 without waiting for a clk edge; after release, the flow restarts cleanly from the first press.
